score_display: RTL and testbench



---
 rtl/score_display.sv | 200 ++++++++++++++++++++
 tb/tb_score_display.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Multi-digit decimal score overlay: sequential binary-to-BCD conversion plus registered 3x5 glyph rendering.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (last digit always drawn).
module score_display #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned BIN_W      = 14,
    parameter logic [9:0]  H_POS      = 10'd30,
    parameter logic [9:0]  V_POS      = 10'd30,
    parameter int unsigned CELL_SHIFT = 4,
    parameter logic [23:0] COLOR      = 24'hff0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    input  logic [9:0]       hcounter,
    input  logic [9:0]       vcounter,
    output logic             busy,
    output logic             visible,
    output logic [23:0]      rgb
);

    localparam int unsigned BCD_W   = DIGITS * 4;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned CELL    = 1 << CELL_SHIFT;
    localparam int unsigned AREA_W  = DIGITS * 4 * CELL;
    localparam int unsigned AREA_H  = 5 * CELL;
    localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state, state_nx;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   bcd, bcd_adj, disp;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic               pend_vld;
    logic [BIN_W-1:0]   pend_val;
    logic               start, commit;
    logic [BIN_W-1:0]   start_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state; a load or pending value during COMMIT restarts conversion on the commit edge
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        commit    = 1'b0;
        start_val = value;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = SHIFT;
                    start    = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(BIN_W - 1)) state_nx = COMMIT;
            end
            COMMIT: begin
                commit = 1'b1;
                if (load) begin
                    state_nx = SHIFT;
                    start    = 1'b1;
                end else if (pend_vld) begin
                    state_nx  = SHIFT;
                    start     = 1'b1;
                    start_val = pend_val;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Only the low DIGITS nibbles are kept; overflow is covered by the capture-time saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            disp     <= '0;
            pend_vld <= 1'b0;
            pend_val <= '0;
            busy     <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            if (start) begin
                shreg <= start_val;
                bcd   <= '0;
                cnt   <= '0;
                sat   <= (32'(start_val) > MAX_VAL);
            end else if (state == SHIFT) begin
                {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
                cnt          <= cnt + CNT_W'(1);
            end
            if (commit) disp <= sat ? {DIGITS{4'd9}} : bcd;
            if (commit && start) begin
                pend_vld <= 1'b0;
            end else if (load && state != IDLE) begin
                pend_vld <= 1'b1;
                pend_val <= value;
            end
        end
    end

    function automatic logic [14:0] glyph(input logic [3:0] d);
        case (d)
            4'd1:    glyph = 15'b001_001_001_001_001;
            4'd2:    glyph = 15'b111_001_111_100_111;
            4'd3:    glyph = 15'b111_001_111_001_111;
            4'd4:    glyph = 15'b101_101_111_001_001;
            4'd5:    glyph = 15'b111_100_111_001_111;
            4'd6:    glyph = 15'b111_100_111_101_111;
            4'd7:    glyph = 15'b111_001_001_001_001;
            4'd8:    glyph = 15'b111_101_111_101_111;
            4'd9:    glyph = 15'b111_101_111_001_001;
            default: glyph = 15'b111_101_101_101_111;
        endcase
    endfunction

    logic [9:0]        dx, dy, idx;
    logic [1:0]        col;
    logic [2:0]        row;
    logic [3:0]        nib;
    logic [DIGITS-1:0] lead;
    logic [14:0]       g;
    logic [2:0]        rbits;
    logic              in_area, blank, lit_c;

    // Leading-zero mask from the displayed register only
    always_comb begin
        lead = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lz;
            lz = 1'b1;
            for (int i = 0; i < int'(DIGITS) - 1; i++) begin
                lz      = lz && (disp[(int'(DIGITS)-1-i)*4 +: 4] == 4'd0);
                lead[i] = lz;
            end
        end
`endif
    end

    always_comb begin
        dx      = hcounter - H_POS;
        dy      = vcounter - V_POS;
        idx     = dx >> (CELL_SHIFT + 2);
        col     = 2'(dx >> CELL_SHIFT);
        row     = 3'(dy >> CELL_SHIFT);
        in_area = (hcounter >= H_POS) && (vcounter >= V_POS) &&
                  (32'(dx) < AREA_W) && (32'(dy) < AREA_H) && (col != 2'd3);
        nib   = 4'd0;
        blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == 10'(i)) begin
                nib   = disp[(int'(DIGITS)-1-i)*4 +: 4];
                blank = lead[i];
            end
        end
        g = glyph(nib);
        case (row)
            3'd0:    rbits = g[14:12];
            3'd1:    rbits = g[11:9];
            3'd2:    rbits = g[8:6];
            3'd3:    rbits = g[5:3];
            3'd4:    rbits = g[2:0];
            default: rbits = 3'd0;
        endcase
        case (col)
            2'd0:    lit_c = rbits[2];
            2'd1:    lit_c = rbits[1];
            default: lit_c = rbits[0];
        endcase
        lit_c = lit_c && in_area && !blank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            visible <= 1'b0;
            rgb     <= '0;
        end else begin
            visible <= lit_c;
            rgb     <= lit_c ? COLOR : 24'd0;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed latency/pending/reset steps plus random loads and pixels.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic [9:0]  hcounter, vcounter;
    logic        busy, visible;
    logic [23:0] rgb;

    int n_cmp = 0;
    int n_err = 0;
    int disp_val = 0;

    int font [10][5] = '{'{7,5,5,5,7}, '{1,1,1,1,1}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
                         '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,1}};
    int pw [4] = '{1000, 100, 10, 1};

    score_display dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .hcounter(hcounter), .vcounter(vcounter),
        .busy(busy), .visible(visible), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected lit state of pixel (h,v) when the display holds decimal val
    function automatic int vis_model(input int h, input int v, input int val);
        int dx, dy, d, col, row, dig;
        if (h < 30 || v < 30) return 0;
        dx = h - 30;
        dy = v - 30;
        d = dx / 64;
        if (d >= 4) return 0;
        col = (dx % 64) / 16;
        if (col == 3) return 0;
        row = dy / 16;
        if (row >= 5) return 0;
        dig = (val / pw[d]) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (d < 3 && val / pw[d] == 0) return 0;
`endif
        return (font[dig][row] >> (2 - col)) & 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_pix(input string tag, input int val);
        int e;
        e = vis_model(int'(hcounter), int'(vcounter), val);
        chk({tag, "_vis"}, 32'(visible), 32'(e));
        chk({tag, "_rgb"}, 32'(rgb), (e != 0) ? 32'h00ff0000 : 32'h0);
    endtask

    task automatic check_px(input int h, input int v);
        hcounter = 10'(h);
        vcounter = 10'(v);
        tick();
        chk_pix("pixel", disp_val);
    endtask

    // Load v with pixel (h,py) parked; check busy window and display switch timing
    task automatic run_conv(input int v, input int h, input int py);
        int nv;
        nv = (v > 9999) ? 9999 : v;
        value = 14'(v);
        load = 1'b1;
        hcounter = 10'(h);
        vcounter = 10'(py);
        tick();
        load = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            chk("conv_busy", 32'(busy), (k <= 14) ? 32'd1 : 32'd0);
            chk_pix("conv", (k <= 15) ? disp_val : nv);
            if (k < 16) tick();
        end
        disp_val = nv;
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        value = '0;
        hcounter = 10'd30;
        vcounter = 10'd30;
        tick(); tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vis", 32'(visible), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        rst_n = 1'b1;
        tick();
        chk_pix("post_rst", 0);

        run_conv(1234, 46, 46);
        check_px(46, 46);
        check_px(62, 46);
        check_px(30, 30);
        check_px(30 + 48, 30);
        run_conv(12000, 254, 46);
        check_px(30 + 192, 30 + 64);
        run_conv(9999, 30, 46);
        run_conv(0, 254, 46);
        check_px(30 + 16, 30 + 16);

        // Load 5 then 7 and 8 while busy: 5 commits, 8 follows immediately, 7 never shows
        value = 14'd5;
        load = 1'b1;
        hcounter = 10'd254;
        vcounter = 10'd46;
        tick();
        load = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            chk("pend_busy", 32'(busy), (k <= 29) ? 32'd1 : 32'd0);
            chk_pix("pend", (k <= 15) ? disp_val : ((k <= 30) ? 5 : 8));
            load = 1'b0;
            if (k == 3) begin value = 14'd7; load = 1'b1; end
            if (k == 6) begin value = 14'd8; load = 1'b1; end
            if (k < 32) tick();
        end
        load = 1'b0;
        disp_val = 8;

        // Reset during SHIFT of 4321 aborts it
        value = 14'd4321;
        load = 1'b1;
        hcounter = 10'd46;
        vcounter = 10'd30;
        tick();
        load = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vis", 32'(visible), 32'd0);
        tick();
        rst_n = 1'b1;
        disp_val = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("after_abort_busy", 32'(busy), 32'd0);
            chk_pix("after_abort", 0);
        end
        check_px(30 + 192, 30);
        check_px(30 + 192 + 16, 30 + 16);

        // Random loads (including saturating values) and random pixel probes
        for (int n = 0; n < 16; n++) begin
            int v;
            case (n % 4)
                0: v = int'($urandom_range(0, 16383));
                1: v = int'($urandom_range(9990, 10010));
                2: v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, 9999));
            endcase
            run_conv(v, int'($urandom_range(30, 285)), int'($urandom_range(30, 109)));
            for (int p = 0; p < 10; p++)
                check_px(int'($urandom_range(0, 320)), int'($urandom_range(0, 120)));
        end

        // LZB spot checks for 42: digit 2 top-left lit, digits 0/1 depend on blanking
        run_conv(42, 30 + 128, 30);
        check_px(30 + 128, 30);
        check_px(30, 30);
        check_px(30 + 64, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
